trace_dump_ctrl: RTL and testbench

//  Host-side command engine on the user side of the UART FIFO interface: pops command bytes

---
 rtl/trace_dump_pkg.sv | 38 +++
 rtl/trace_dump_tx_slot.sv | 47 ++++
 rtl/trace_dump_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_trace_dump_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_dump_pkg.sv
// -----------------------------------------------------------------------------
// trace_dump_pkg
// Shared constants and types for the trace dump command engine.
//   - Command / response byte codes seen on the UART FIFO interface.
//   - FSM state encoding used by trace_dump_ctrl.
//   - len_to_cnt(): maps the LEN command byte to the 9-bit byte count.
// Configuration macro: DUMP_CHECKSUM_EN (adds the ST_SEND_SUM state).
// -----------------------------------------------------------------------------
package trace_dump_pkg;

    localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
    localparam logic [7:0] CMD_PING = 8'h50;  // 'P'
    localparam logic [7:0] RSP_ACK  = 8'h41;  // 'A'
    localparam logic [7:0] RSP_PONG = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_NAK  = 8'h3F;  // '?'

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_AH    = 4'd1,
        ST_GET_AL    = 4'd2,
        ST_GET_LEN   = 4'd3,
        ST_SEND_ACK  = 4'd4,
        ST_MEM_REQ   = 4'd5,
        ST_MEM_WAIT  = 4'd6,
        ST_SEND_DATA = 4'd7,
        ST_SEND_PONG = 4'd8,
        ST_SEND_NAK  = 4'd9
`ifdef DUMP_CHECKSUM_EN
        , ST_SEND_SUM = 4'd10
`endif
    } state_e;

    // LEN byte of zero requests a full 256-byte dump.
    function automatic logic [8:0] len_to_cnt(input logic [7:0] len);
        return (len == 8'h00) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/trace_dump_tx_slot.sv
// -----------------------------------------------------------------------------
// trace_dump_tx_slot
// One-byte holding register in front of the TX FIFO. The controller loads a
// byte whenever o_ready is high; the byte is pushed with write_enable as soon
// as the FIFO is not full, and held (data stable) while it is full.
// Ports:
//   clock, reset_n   clock / asynchronous active-low reset
//   i_load, i_data   load request and byte from the controller
//   i_fifo_full      TX FIFO full flag
//   o_ready          slot can accept a byte this cycle
//   o_data           byte presented to the TX FIFO
//   o_write_enable   push strobe into the TX FIFO
// -----------------------------------------------------------------------------
module trace_dump_tx_slot (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_fifo_full,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_write_enable
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       w_push;

    assign w_push         = r_valid & ~i_fifo_full;
    // A byte leaving this cycle frees the slot for a back-to-back load.
    assign o_ready        = ~r_valid | w_push;
    assign o_data         = r_data;
    assign o_write_enable = w_push;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_push) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/trace_dump_ctrl.sv
// -----------------------------------------------------------------------------
// trace_dump_ctrl
// Host command engine between the UART FIFOs and the trace RAM read port.
// Pops command bytes from the RX FIFO, reads trace bytes from memory and pushes
// replies into the TX FIFO:
//   'D' AH AL LEN -> 'A' + LEN data bytes (LEN=0 -> 256) [+ checksum]
//   'P'           -> 'K'
//   other         -> '?' with a cmd_error pulse
// Ports:
//   clock, reset_n                 clock / asynchronous active-low reset
//   rx_data, rx_data_ready         show-ahead RX FIFO head and not-empty
//   read_enable                    RX FIFO pop strobe
//   tx_data, write_enable          TX FIFO data and push strobe
//   tx_fifo_full                   TX FIFO full flag
//   mem_addr, mem_rd, mem_data     trace memory read port (1-cycle latency)
//   busy                           FSM not idle
//   cmd_error                      pulse on unknown command or header timeout
// Configuration macro: DUMP_CHECKSUM_EN appends the mod-256 sum of the data
// bytes after the last data byte.
// -----------------------------------------------------------------------------
module trace_dump_ctrl
    import trace_dump_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 83320
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    output logic              read_enable,
    output logic [7:0]        tx_data,
    output logic              write_enable,
    input  logic              tx_fifo_full,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              cmd_error
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e            r_state;
    logic              r_active;
    logic              r_popped;
    logic              r_cmd_error;
    logic [TMO_W-1:0]  r_tmo;
    logic [7:0]        r_ah;
    logic [7:0]        r_mem_byte;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_cnt;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic              w_rx_state;
    logic              w_get_state;
    logic              w_pop;
    logic              w_tmo_hit;
    logic              w_slot_ready;
    logic              w_load;
    logic [7:0]        w_load_data;
    logic [15:0]       w_cmd_addr;

    assign w_get_state = (r_state == ST_GET_AH) || (r_state == ST_GET_AL) ||
                         (r_state == ST_GET_LEN);
    assign w_rx_state  = w_get_state || (r_state == ST_IDLE);
    // r_active keeps read_enable low until the cycle after reset release;
    // r_popped enforces one idle cycle between consecutive pops.
    assign w_pop       = r_active & w_rx_state & rx_data_ready & ~r_popped;
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    assign w_cmd_addr  = {r_ah, rx_data};

    assign read_enable = w_pop;
    assign mem_addr    = r_addr;
    assign mem_rd      = (r_state == ST_MEM_REQ);
    assign busy        = (r_state != ST_IDLE);
    assign cmd_error   = r_cmd_error;

    // Byte offered to the TX slot by each sending state.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = 8'h00;
        case (r_state)
            ST_SEND_ACK:  begin w_load = w_slot_ready; w_load_data = RSP_ACK;    end
            ST_SEND_DATA: begin w_load = w_slot_ready; w_load_data = r_mem_byte; end
            ST_SEND_PONG: begin w_load = w_slot_ready; w_load_data = RSP_PONG;   end
            ST_SEND_NAK:  begin w_load = w_slot_ready; w_load_data = RSP_NAK;    end
`ifdef DUMP_CHECKSUM_EN
            ST_SEND_SUM:  begin w_load = w_slot_ready; w_load_data = r_sum;      end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_active    <= 1'b0;
            r_popped    <= 1'b0;
            r_cmd_error <= 1'b0;
            r_tmo       <= '0;
            r_ah        <= 8'h00;
            r_mem_byte  <= 8'h00;
            r_addr      <= '0;
            r_cnt       <= 9'd0;
`ifdef DUMP_CHECKSUM_EN
            r_sum       <= 8'h00;
`endif
        end else begin
            r_active    <= 1'b1;
            r_popped    <= w_pop;
            r_cmd_error <= 1'b0;

            // Header timeout: reloads on every popped byte, counts otherwise.
            if (w_pop) begin
                r_tmo <= '0;
            end else if (w_get_state) begin
                if (w_tmo_hit) begin
                    r_state     <= ST_IDLE;
                    r_cmd_error <= 1'b1;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: if (w_pop) begin
                    if (rx_data == CMD_DUMP) begin
                        r_state <= ST_GET_AH;
                    end else if (rx_data == CMD_PING) begin
                        r_state <= ST_SEND_PONG;
                    end else begin
                        r_state     <= ST_SEND_NAK;
                        r_cmd_error <= 1'b1;
                    end
                end
                ST_GET_AH: if (w_pop) begin
                    r_ah    <= rx_data;
                    r_state <= ST_GET_AL;
                end
                ST_GET_AL: if (w_pop) begin
                    r_addr  <= w_cmd_addr[ADDR_W-1:0];
                    r_state <= ST_GET_LEN;
                end
                ST_GET_LEN: if (w_pop) begin
                    r_cnt   <= len_to_cnt(rx_data);
`ifdef DUMP_CHECKSUM_EN
                    r_sum   <= 8'h00;
`endif
                    r_state <= ST_SEND_ACK;
                end
                ST_SEND_ACK: if (w_load) r_state <= ST_MEM_REQ;
                ST_MEM_REQ:  r_state <= ST_MEM_WAIT;
                ST_MEM_WAIT: begin
                    r_mem_byte <= mem_data;
                    r_state    <= ST_SEND_DATA;
                end
                ST_SEND_DATA: if (w_load) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_cnt  <= r_cnt - 9'd1;
`ifdef DUMP_CHECKSUM_EN
                    r_sum  <= r_sum + r_mem_byte;
                    r_state <= (r_cnt == 9'd1) ? ST_SEND_SUM : ST_MEM_REQ;
`else
                    r_state <= (r_cnt == 9'd1) ? ST_IDLE : ST_MEM_REQ;
`endif
                end
`ifdef DUMP_CHECKSUM_EN
                ST_SEND_SUM:  if (w_load) r_state <= ST_IDLE;
`endif
                ST_SEND_PONG: if (w_load) r_state <= ST_IDLE;
                ST_SEND_NAK:  if (w_load) r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    trace_dump_tx_slot u_tx_slot (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_load         (w_load),
        .i_data         (w_load_data),
        .i_fifo_full    (tx_fifo_full),
        .o_ready        (w_slot_ready),
        .o_data         (tx_data),
        .o_write_enable (write_enable)
    );

endmodule

// File: tb/tb_trace_dump_ctrl.sv
`timescale 1ns/1ps
module tb_trace_dump_ctrl;

    localparam int ADDR_W = 16;
    localparam int TMO    = 300;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        rx_data;
    logic              rx_data_ready;
    logic              read_enable;
    logic [7:0]        tx_data;
    logic              write_enable;
    logic              tx_fifo_full = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data = 8'h00;
    logic              busy;
    logic              cmd_error;

    trace_dump_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .read_enable   (read_enable),
        .tx_data       (tx_data),
        .write_enable  (write_enable),
        .tx_fifo_full  (tx_fifo_full),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .busy          (busy),
        .cmd_error     (cmd_error)
    );

    always #5 clock = ~clock;

    // RX FIFO model (show-ahead)
    logic [7:0] rx_buf [0:255];
    int rx_len = 0;
    int rx_idx = 0;
    assign rx_data_ready = (rx_idx < rx_len);
    assign rx_data       = rx_data_ready ? rx_buf[rx_idx] : 8'h00;

    // Trace memory model and monitors
    logic [7:0]  mem_arr [0:65535];
    logic [7:0]  tx_q [$];
    logic [15:0] addr_q [$];
    logic [7:0]  exp_q [$];
    int err_pulses = 0;
    int full_viol  = 0;
    int pop_viol   = 0;
    logic prev_re  = 1'b0;

    always @(posedge clock) begin
        if (read_enable) rx_idx <= rx_idx + 1;
        if (read_enable && prev_re) pop_viol++;
        prev_re <= read_enable;
        if (write_enable) begin
            if (tx_fifo_full) full_viol++;
            else tx_q.push_back(tx_data);
        end
        if (cmd_error) err_pulses++;
        if (mem_rd) addr_q.push_back(mem_addr);
        mem_data <= mem_rd ? mem_arr[mem_addr] : 8'hEE;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_buf[rx_len] = b;
        rx_len++;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (tx_q.size() >= n && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge clock);
    endtask

    task automatic ping_check(input string name);
        bit ok;
        tx_q.delete();
        err_pulses = 0;
        push_rx(8'h50);
        wait_done(1, 200, ok);
        check({name, " done"}, int'(ok), 1);
        check({name, " len"}, tx_q.size(), 1);
        check({name, " byte"}, (tx_q.size() > 0) ? int'(tx_q[0]) : -1, 8'h4B);
        check({name, " err"}, err_pulses, 0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] cmd;
        int          ncmd;
        logic [39:0] exp;
        int          nexp;
        logic [7:0]  sum;
        bit          is_dump;
        int          exp_err;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        bit ok;
        logic [7:0]  cb;
        logic [15:0] a;
        logic [7:0]  sum;
        int bad, abad, sz;

        for (int i = 0; i < 65536; i++) mem_arr[i] = pat(16'(i));
        mem_arr[16'h1234] = 8'hAA;
        mem_arr[16'h1235] = 8'hBB;
        mem_arr[16'h1236] = 8'hCC;

        vecs[0] = '{"ping",      32'h5000_0000, 1, 40'h4B_0000_0000, 1, 8'h00, 1'b0, 0};
        vecs[1] = '{"nak13",     32'h1300_0000, 1, 40'h3F_0000_0000, 1, 8'h00, 1'b0, 1};
        vecs[2] = '{"nakFF",     32'hFF00_0000, 1, 40'h3F_0000_0000, 1, 8'h00, 1'b0, 1};
        vecs[3] = '{"nak41",     32'h4100_0000, 1, 40'h3F_0000_0000, 1, 8'h00, 1'b0, 1};
        vecs[4] = '{"dump1234",  32'h4412_3403, 4, 40'h41_AABB_CC00, 4, 8'h31, 1'b1, 0};
        vecs[5] = '{"dump0010",  32'h4400_1001, 4, 40'h41_4A00_0000, 2, 8'h4A, 1'b1, 0};
        vecs[6] = '{"dumpABCD",  32'h44AB_CD02, 4, 40'h41_3C3F_0000, 3, 8'h7B, 1'b1, 0};
        vecs[7] = '{"ping2",     32'h5000_0000, 1, 40'h4B_0000_0000, 1, 8'h00, 1'b0, 0};

        // Reset state
        #12;
        check("rst read_enable", int'(read_enable), 0);
        check("rst write_enable", int'(write_enable), 0);
        check("rst tx_data", int'(tx_data), 0);
        check("rst mem_rd", int'(mem_rd), 0);
        check("rst mem_addr", int'(mem_addr), 0);
        check("rst busy", int'(busy), 0);
        check("rst cmd_error", int'(cmd_error), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Table-driven commands
        for (int v = 0; v < NV; v++) begin
            tx_q.delete();
            err_pulses = 0;
            exp_q.delete();
            for (int k = 0; k < vecs[v].ncmd; k++) begin
                cb = vecs[v].cmd[31-8*k -: 8];
                push_rx(cb);
            end
            for (int k = 0; k < vecs[v].nexp; k++) exp_q.push_back(vecs[v].exp[39-8*k -: 8]);
`ifdef DUMP_CHECKSUM_EN
            if (vecs[v].is_dump) exp_q.push_back(vecs[v].sum);
`endif
            wait_done(exp_q.size(), 2000, ok);
            check({vecs[v].name, " done"}, int'(ok), 1);
            check({vecs[v].name, " len"}, tx_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size(); k++)
                check({vecs[v].name, " byte"}, (k < tx_q.size()) ? int'(tx_q[k]) : -1, int'(exp_q[k]));
            check({vecs[v].name, " err"}, err_pulses, vecs[v].exp_err);
            check({vecs[v].name, " busy"}, int'(busy), 0);
        end

        // Wrap-around, LEN=0 -> 256 bytes from 0xFFFF
        tx_q.delete();
        addr_q.delete();
        push_rx(8'h44); push_rx(8'hFF); push_rx(8'hFF); push_rx(8'h00);
`ifdef DUMP_CHECKSUM_EN
        wait_done(258, 3000, ok);
        check("wrap len", tx_q.size(), 258);
`else
        wait_done(257, 3000, ok);
        check("wrap len", tx_q.size(), 257);
`endif
        check("wrap done", int'(ok), 1);
        check("wrap ack", (tx_q.size() > 0) ? int'(tx_q[0]) : -1, 8'h41);
        check("wrap first data", (tx_q.size() > 1) ? int'(tx_q[1]) : -1, 8'h5A);
        check("wrap addr count", addr_q.size(), 256);
        check("wrap addr1", (addr_q.size() > 1) ? int'(addr_q[1]) : -1, 0);
        bad = 0; abad = 0; sum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            a = 16'hFFFF + 16'(i);
            sum = sum + mem_arr[a];
            if (i + 1 >= tx_q.size() || tx_q[i+1] != mem_arr[a]) bad++;
            if (i >= addr_q.size() || addr_q[i] != a) abad++;
        end
        check("wrap data mismatches", bad, 0);
        check("wrap addr mismatches", abad, 0);
`ifdef DUMP_CHECKSUM_EN
        check("wrap sum", (tx_q.size() > 257) ? int'(tx_q[257]) : -1, int'(sum));
`endif

        // Backpressure: 16 bytes from 0x0100, FIFO full 50 cycles mid-dump
        tx_q.delete();
        push_rx(8'h44); push_rx(8'h01); push_rx(8'h00); push_rx(8'h10);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (tx_q.size() >= 4) begin ok = 1'b1; break; end
        end
        check("bp reach", int'(ok), 1);
        tx_fifo_full = 1'b1;
        sz = tx_q.size();
        repeat (50) @(negedge clock);
        check("bp stalled len", tx_q.size(), sz);
        check("bp stalled busy", int'(busy), 1);
        tx_fifo_full = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'h41);
        sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(mem_arr[16'h0100 + 16'(i)]);
            sum = sum + mem_arr[16'h0100 + 16'(i)];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        wait_done(exp_q.size(), 1000, ok);
        check("bp done", int'(ok), 1);
        check("bp len", tx_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= tx_q.size() || tx_q[i] != exp_q[i]) bad++;
        check("bp stream mismatches", bad, 0);
        check("bp write while full", full_viol, 0);

        // Header timeout
        tx_q.delete();
        err_pulses = 0;
        push_rx(8'h44); push_rx(8'h12);
        repeat (TMO / 2) @(negedge clock);
        check("tmo early err", err_pulses, 0);
        check("tmo early busy", int'(busy), 1);
        repeat (TMO) @(negedge clock);
        check("tmo err", err_pulses, 1);
        check("tmo busy", int'(busy), 0);
        check("tmo no tx", tx_q.size(), 0);
        ping_check("tmo ping");

        // Reset in the middle of a dump
        tx_q.delete();
        push_rx(8'h44); push_rx(8'h00); push_rx(8'h00); push_rx(8'h00);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (tx_q.size() >= 10) begin ok = 1'b1; break; end
        end
        check("mid reach", int'(ok), 1);
        reset_n = 1'b0;
        #1;
        check("mid rst busy", int'(busy), 0);
        check("mid rst mem_rd", int'(mem_rd), 0);
        check("mid rst mem_addr", int'(mem_addr), 0);
        check("mid rst write_enable", int'(write_enable), 0);
        check("mid rst tx_data", int'(tx_data), 0);
        check("mid rst cmd_error", int'(cmd_error), 0);
        check("mid rst read_enable", int'(read_enable), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("mid after busy", int'(busy), 0);
        ping_check("mid ping");

        check("pop spacing violations", pop_viol, 0);
        check("write while full", full_viol, 0);
        check("rx all consumed", rx_idx, rx_len);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
